// File: rtl/cordic_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_result_collector
//  Purpose  : Tracks CORDIC requests through a latency-matched tag pipe and
//             buffers tagged r/a results in a FWFT FIFO with valid/ready drain.
//  Revision : 1.0 - initial release
// ============================================================================
module cordic_result_collector #(
    parameter int OUT_WIDTH = 16,
    parameter int LATENCY   = 16,
    parameter int DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_in,
    input  logic [1:0]                mode_in,
    input  logic [OUT_WIDTH-1:0]      r_in,
    input  logic [OUT_WIDTH-1:0]      a_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_mode,
    output logic [7:0]                out_seq,
    output logic [OUT_WIDTH-1:0]      out_r,
    output logic [OUT_WIDTH-1:0]      out_a,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_TAG_W = 11;
    localparam int c_ENT_W = 10 + 2 * OUT_WIDTH;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

    // Tag layout: {valid, mode[1:0], seq[7:0]}
    logic [c_TAG_W-1:0]   r_tag [LATENCY];
    logic [7:0]           r_seq;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic                 r_overflow;
    logic [c_ENT_W-1:0]   r_mem [DEPTH];

    logic                 w_accept;
    logic [c_TAG_W-1:0]   w_tag_in;
    logic [7:0]           w_seq_nxt;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic [c_PTR_W-1:0]   w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]   w_rd_ptr_nxt;
    logic [c_LVL_W-1:0]   w_level_nxt;
    logic                 w_overflow_nxt;
    logic [c_ENT_W-1:0]   w_wr_data;
    logic [c_ENT_W-1:0]   w_head;

    always_comb begin
        w_accept  = en_in && ((mode_in == 2'd1) || (mode_in == 2'd2));
        w_tag_in  = w_accept ? {1'b1, mode_in, r_seq} : '0;
        w_seq_nxt = r_seq + {7'd0, w_accept};

        w_capture = r_tag[LATENCY-1][c_TAG_W-1];
        w_pop     = (r_level != '0) && out_ready;
        w_full    = (r_level == c_FULL);
        // A full FIFO still takes the push when the head leaves in the same cycle
        w_push    = w_capture && (!w_full || w_pop);
        w_wr_data = {r_tag[LATENCY-1][9:0], r_in, a_in};

        w_wr_ptr_nxt   = w_push ? r_wr_ptr + c_PTR_W'(1) : r_wr_ptr;
        w_rd_ptr_nxt   = w_pop  ? r_rd_ptr + c_PTR_W'(1) : r_rd_ptr;
        w_overflow_nxt = r_overflow | (w_capture & w_full & ~w_pop);

        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_LVL_W'(1);
            2'b01:   w_level_nxt = r_level - c_LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_tag[i] <= '0;
            end
            r_seq      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_seq      <= w_seq_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_level    <= w_level_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Storage needs no reset: the level counter alone decides what is visible
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    always_comb begin
        w_head    = r_mem[r_rd_ptr];
        out_valid = (r_level != '0);
        out_mode  = '0;
        out_seq   = '0;
        out_r     = '0;
        out_a     = '0;
        if (out_valid) begin
            out_mode = w_head[c_ENT_W-1 -: 2];
            out_seq  = w_head[c_ENT_W-3 -: 8];
            out_r    = w_head[2*OUT_WIDTH-1 -: OUT_WIDTH];
            out_a    = w_head[OUT_WIDTH-1:0];
        end
        level    = r_level;
        overflow = r_overflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_result_collector
//  Purpose  : Directed self-checking bench for cordic_result_collector.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_result_collector;

    localparam int OUT_WIDTH = 16;
    localparam int LATENCY   = 16;
    localparam int DEPTH     = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 en_in = 1'b0;
    logic [1:0]           mode_in = 2'd0;
    logic [OUT_WIDTH-1:0] r_in;
    logic [OUT_WIDTH-1:0] a_in;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [1:0]           out_mode;
    logic [7:0]           out_seq;
    logic [OUT_WIDTH-1:0] out_r;
    logic [OUT_WIDTH-1:0] out_a;
    logic [$clog2(DEPTH):0] level;
    logic                 overflow;

    int tests    = 0;
    int fails    = 0;
    int edge_cnt = 0;
    int k        = 0;
    int vcnt     = 0;

    cordic_result_collector #(
        .OUT_WIDTH (OUT_WIDTH),
        .LATENCY   (LATENCY),
        .DEPTH     (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_in     (en_in),
        .mode_in   (mode_in),
        .r_in      (r_in),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_seq   (out_seq),
        .out_r     (out_r),
        .out_a     (out_a),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Stand-in CORDIC outputs: value depends only on the edge that samples it
    function automatic logic [15:0] rv(input int e);
        return 16'(32'h4000 + e);
    endfunction

    function automatic logic [15:0] av(input int e);
        return 16'hC000 ^ 16'(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
        r_in = rv(edge_cnt + 1);
        a_in = av(edge_cnt + 1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        en_in = 1'b0;
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        r_in = rv(1);
        a_in = av(1);

        // Reset held with traffic present
        en_in = 1'b1; mode_in = 2'd1; out_ready = 1'b1;
        repeat (3) step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_mode", 32'(out_mode), 0);
        chk("rst_seq", 32'(out_seq), 0);
        chk("rst_r", 32'(out_r), 0);
        chk("rst_a", 32'(out_a), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b0; en_in = 1'b0;
        step();

        // Single request: captured exactly LATENCY edges later, visible one cycle
        en_in = 1'b1; mode_in = 2'd1;
        step(); k = edge_cnt;
        en_in = 1'b0;
        repeat (15) step();
        chk("single_early", 32'(out_valid), 0);
        step();
        chk("single_valid", 32'(out_valid), 1);
        chk("single_mode", 32'(out_mode), 1);
        chk("single_seq", 32'(out_seq), 0);
        chk("single_r", 32'(out_r), 32'(rv(k + 16)));
        chk("single_a", 32'(out_a), 32'(av(k + 16)));
        step();
        chk("single_gone", 32'(out_valid), 0);

        // Back-to-back burst, 8 vectoring then 8 rotation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            en_in = 1'b1; mode_in = (i < 8) ? 2'd1 : 2'd2;
            step();
        end
        en_in = 1'b0;
        for (int j = 0; j < 16; j++) begin
            step();
            chk("burst_valid", 32'(out_valid), 1);
            chk("burst_seq", 32'(out_seq), 32'(j));
            chk("burst_mode", 32'(out_mode), (j < 8) ? 1 : 2);
            chk("burst_level", 32'(level), 1);
        end
        step();
        chk("burst_end_valid", 32'(out_valid), 0);
        chk("burst_end_level", 32'(level), 0);

        // Backpressure: six requests into a four-deep FIFO
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en_in = 1'b1; mode_in = 2'd1;
            step();
            if (i == 0) k = edge_cnt;
        end
        en_in = 1'b0;
        repeat (10) step();
        chk("bp_level0", 32'(level), 0);
        for (int j = 0; j < 4; j++) begin
            step();
            chk("bp_fill_level", 32'(level), 32'(j + 1));
        end
        chk("bp_no_ovf_yet", 32'(overflow), 0);
        step();
        chk("bp_ovf_level", 32'(level), 4);
        chk("bp_ovf_set", 32'(overflow), 1);
        chk("bp_head_seq", 32'(out_seq), 0);
        chk("bp_head_r", 32'(out_r), 32'(rv(k + 16)));
        step();
        chk("bp_level_hold", 32'(level), 4);
        chk("bp_head_hold", 32'(out_seq), 0);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_drain_seq", 32'(out_seq), 32'(j));
            chk("bp_drain_r", 32'(out_r), 32'(rv(k + 16 + j)));
            chk("bp_drain_a", 32'(out_a), 32'(av(k + 16 + j)));
            step();
        end
        chk("bp_empty_level", 32'(level), 0);
        chk("bp_empty_valid", 32'(out_valid), 0);
        chk("bp_ovf_sticky", 32'(overflow), 1);

        // Full FIFO with a pop on the capture edge
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en_in = 1'b1; mode_in = 2'd2;
            step();
            if (i == 0) k = edge_cnt;
        end
        en_in = 1'b0;
        repeat (15) step();
        chk("fp_full", 32'(level), 4);
        out_ready = 1'b1;
        step();
        chk("fp_level", 32'(level), 4);
        chk("fp_no_ovf", 32'(overflow), 0);
        chk("fp_head", 32'(out_seq), 1);
        for (int j = 2; j < 5; j++) begin
            step();
            chk("fp_order", 32'(out_seq), 32'(j));
        end
        chk("fp_new_r", 32'(out_r), 32'(rv(k + 20)));
        step();
        chk("fp_empty", 32'(out_valid), 0);

        // Ignored modes: seq must remain at 5
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            en_in = 1'b1; mode_in = (i % 2 == 1) ? 2'd3 : 2'd0;
            step();
            if (out_valid) vcnt++;
        end
        en_in = 1'b0;
        repeat (20) begin
            step();
            if (out_valid) vcnt++;
        end
        chk("ign_no_capture", 32'(vcnt), 0);
        en_in = 1'b1; mode_in = 2'd2;
        step();
        en_in = 1'b0;
        repeat (16) step();
        chk("ign_valid", 32'(out_valid), 1);
        chk("ign_seq", 32'(out_seq), 5);
        chk("ign_mode", 32'(out_mode), 2);

        // Sequence wrap over 257 back-to-back requests
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t <= 272; t++) begin
            en_in = (t < 257);
            mode_in = (t % 2 == 1) ? 2'd2 : 2'd1;
            step();
            if (t >= 16) begin
                chk("wrap_valid", 32'(out_valid), 1);
                chk("wrap_seq", 32'(out_seq), 32'((t - 16) % 256));
            end
        end
        en_in = 1'b0;
        step();
        chk("wrap_end", 32'(out_valid), 0);

        // Reset pulse with buffered entries and tags in flight
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en_in = 1'b1; mode_in = 2'd1;
            step();
        end
        en_in = 1'b0;
        repeat (16) step();
        chk("mf_buffered", 32'(level), 2);
        for (int i = 0; i < 5; i++) begin
            en_in = 1'b1; mode_in = 2'd2;
            step();
        end
        en_in = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mf_async_level", 32'(level), 0);
        chk("mf_async_valid", 32'(out_valid), 0);
        chk("mf_async_seq", 32'(out_seq), 0);
        step();
        rst_n = 1'b0;
        vcnt = 0;
        repeat (40) begin
            step();
            if (out_valid) vcnt++;
        end
        chk("mf_no_stale", 32'(vcnt), 0);
        en_in = 1'b1; mode_in = 2'd1;
        step();
        en_in = 1'b0;
        repeat (16) step();
        chk("mf_new_valid", 32'(out_valid), 1);
        chk("mf_new_seq", 32'(out_seq), 0);
        chk("mf_ovf_clear", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cordic_result_collector.md
# cordic_result_collector

Output-side companion to `cordic_top`. It tracks every request issued to the CORDIC pipeline through a tag delay line matched to the pipeline latency. When the tag emerges, it captures the corresponding `r_out`/`a_out`, labels the result with mode and sequence number, and buffers it in a small FIFO. Downstream logic drains the FIFO through a valid/ready handshake. It sits beside `cordic_top`, snooping the same `en`/`mode` lines that drive it.

## Interface
- `OUT_WIDTH`, 16, width of the CORDIC `r_out`/`a_out` results.
- `LATENCY`, 16, number of clock edges from request sample to result at `cordic_top` outputs; must be ≥1.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-high.
- `en_in`  in  1  same enable driven to `cordic_top.en_in`.
- `mode_in`  in  2  same mode driven to `cordic_top.mode_in` (1 = vectoring, 2 = rotation).
- `r_in`  in  OUT_WIDTH  `cordic_top.r_out`.
- `a_in`  in  OUT_WIDTH  `cordic_top.a_out`.
- `out_valid`  out  1  FIFO head holds a result.
- `out_ready`  in  1  downstream accepts the head this cycle.
- `out_mode`  out  2  mode of the head result.
- `out_seq`  out  8  sequence number of the head result.
- `out_r`  out  OUT_WIDTH  head r result.
- `out_a`  out  OUT_WIDTH  head a result.
- `level`  out  clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; a result was dropped because the FIFO was full.

## Operation
- **Request acceptance.** A request is accepted at an edge where `en_in`=1 and `mode_in` ∈ {1,2}. `en_in`=1 with mode 0 or 3 is ignored: no tag is created and `seq` does not advance.
- **Sequence counter.** The 8-bit `seq` counter increments on each accepted request and wraps 255→0. Its current value, before the increment, is the request's tag.
- **Tag pipe.** The tag pipe is LATENCY stages, each holding {valid, mode[1:0], seq[7:0]}, and shifts every cycle unconditionally. Stage 0 loads the accepted-request tag, or valid=0 if no request was accepted.
- **Capture.** When the last stage is valid at an edge, {mode, seq, `r_in`, `a_in`} is pushed into the FIFO at that same edge.
- **FIFO.** The FIFO is first-word-fall-through: `out_*` always shows the head entry. `out_valid` = (`level`≠0).
- **Pop.** A pop occurs when `out_valid` && `out_ready`.
- **Push.** A push is accepted if `level` < DEPTH, or if a pop occurs in the same cycle.
- **Simultaneous push and pop.** When both occur, `level` is unchanged and entries advance correctly. This includes the full case, which is not an overflow.
- **Overflow.** A push with `level`=DEPTH and no pop drops the result and sets `overflow`=1. `level` is unchanged and FIFO contents are untouched.
- **Overflow clearing.** `overflow` clears only on reset.
- **Output stability.** While `out_valid`=1 and `out_ready`=0, all `out_*` are held stable.
- **Pointers.** Read and write pointers are clog2(DEPTH) bits and wrap naturally. `level` is tracked explicitly.

## Timing
- **Reset (`rst_n`=1, asynchronous).**
  - Immediately clears the tag pipe, `seq`, pointers, `level`, and `overflow`.
  - All outputs read 0: `out_valid`, `out_mode`, `out_seq`, `out_r`, `out_a`, `level`, `overflow`.
  - Reset mid-operation discards all in-flight tags and buffered results. Results emerging from `cordic_top` after reset release are not captured unless their request was accepted after release.
- **Latency.** A request sampled at edge k is captured at edge k+LATENCY. `out_valid` is high after edge k+LATENCY when the FIFO was empty. End-to-end latency is therefore LATENCY cycles.
- **Throughput.** One request per cycle, and one result per cycle with `out_ready` held 1. Back-to-back requests produce back-to-back `out_valid` with no bubbles.
- **Pop and level timing.** A pop at edge m removes the head. The next entry, if present, appears after edge m. `level` updates at the same edge as the push or pop.
- **Mode changes.** A mode change between consecutive requests has no effect on timing.

## Test plan
- **Reset and single request.**
  - Assert `rst_n`=1 with traffic present → all outputs 0 and `level`=0.
  - After release, one mode-1 request (x=32767, y=0) with `out_ready`=1 → `out_valid` is high exactly 1 cycle, after edge k+16.
  - The output shows `out_mode`=1, `out_seq`=0, and `out_r`/`out_a` equal to `r_in`/`a_in` sampled at that edge.
- **Back-to-back burst.** Send 8 mode-1 requests followed by 8 mode-2 requests with `out_ready`=1 → 16 consecutive valid cycles with `out_seq` 0..15, `out_mode` 1×8 then 2×8, and `level` ≤1.
- **Backpressure and overflow.**
  - With `out_ready`=0 and DEPTH=4, send 6 requests → `level` saturates at 4.
  - `overflow` rises at the 5th capture edge; the head stays at seq 0.
  - Raise `out_ready` → `out_seq` 0,1,2,3 drain, then `level`=0; `overflow` stays 1.
- **Full with simultaneous pop.** With `level`=4, assert `out_ready`=1 on a capture edge → `level` stays 4, `overflow` stays 0, and the new entry appears after the 3 remaining entries.
- **Ignored modes and wrap.**
  - `en_in`=1 with mode 0 and mode 3 for 10 cycles → no captures, and `seq` is unchanged.
  - 257 valid requests → `out_seq` runs 0..255 and then 0.
- **Reset mid-flight.** Pulse `rst_n`=1 for 1 cycle while 5 tags are in flight and 2 entries are buffered → zero results appear for the pre-reset requests, and the next accepted request yields `out_seq`=0.
